// File: rtl/norm_stage_pkg.sv
// Shared widths and bit positions for the post-add normalisation stage.
package norm_stage_pkg;

    localparam int FRAC_W_DEF = 75;
    localparam int EXP_W_DEF  = 10;
    localparam int MANT_W     = 24;
    localparam int GRS_W      = 3;
    localparam int LZC_IN_W   = 75;
    localparam int LZC_W      = 7;

    // Guard/round sit directly below the mantissa; everything lower folds into sticky.
    localparam int GUARD_POS  = FRAC_W_DEF - MANT_W - 1;
    localparam int ROUND_POS  = FRAC_W_DEF - MANT_W - 2;

    typedef logic [LZC_W-1:0] lzc_t;

endpackage

// File: rtl/norm_stage_lzc75.sv
// Combinational 75-bit leading-zero counter; count is 75 when the input is all zero.
module lzc75
    import norm_stage_pkg::*;
(
    input  logic [LZC_IN_W-1:0] value,
    output lzc_t                count,
    output logic                all_zero
);

    always_comb begin
        count = lzc_t'(LZC_IN_W);
        // Ascending scan: the highest set bit is the last one written.
        for (int unsigned i = 0; i < LZC_IN_W; i++) begin
            if (value[i]) count = lzc_t'(LZC_IN_W - 1 - i);
        end
    end

    assign all_zero = ~|value;

endmodule

// File: rtl/norm_stage.sv
// Two-stage normaliser: S1 registers operands plus leading-zero count, S2 registers the shifted result.
module norm_stage
    import norm_stage_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FRAC_W-1:0]   frac_inter,
    input  logic                frac_inter_h_s,
    input  logic                sign_in,
    input  logic [EXP_W-1:0]    exp_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANT_W-1:0]   mant_out,
    output logic [GRS_W-1:0]    grs_out,
    output logic [EXP_W-1:0]    exp_out,
    output logic                sign_out,
    output logic                zero_out
);

    logic              s1_valid, s2_valid;
    logic [FRAC_W-1:0] s1_frac;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_sign, s1_zero;
    lzc_t              s1_lzc;

    lzc_t              lzc_cnt;
    logic              lzc_zero;
    logic              in_fire, s1_adv;

    lzc75 u_lzc (
        .value    (frac_inter),
        .count    (lzc_cnt),
        .all_zero (lzc_zero)
    );

    assign s1_adv   = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_frac  <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_lzc   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_frac  <= frac_inter;
            s1_exp   <= exp_in;
            s1_sign  <= sign_in ^ frac_inter_h_s;
            s1_zero  <= lzc_zero;
            s1_lzc   <= lzc_cnt;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Shift is capped at exp-1 so denormals land on exponent 1 with a clear hidden bit.
    logic signed [EXP_W:0] exp_ext, exp_m1, lzc_ext;
    lzc_t                  shift;
    logic [FRAC_W-1:0]     shifted;
    logic [EXP_W-1:0]      exp_adj;

    always_comb begin
        exp_ext = signed'({s1_exp[EXP_W-1], s1_exp});
        exp_m1  = exp_ext - signed'((EXP_W+1)'(1));
        lzc_ext = signed'({{(EXP_W+1-LZC_W){1'b0}}, s1_lzc});
        shift   = '0;
        if (exp_ext <= 0)
            shift = '0;
        else if (lzc_ext < exp_m1)
            shift = s1_lzc;
        else
            shift = exp_m1[LZC_W-1:0];
        shifted = s1_frac << shift;
        exp_adj = s1_exp - {{(EXP_W-LZC_W){1'b0}}, shift};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            mant_out <= '0;
            grs_out  <= '0;
            exp_out  <= '0;
            sign_out <= 1'b0;
            zero_out <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            sign_out <= s1_sign;
            zero_out <= s1_zero;
            if (s1_zero) begin
                mant_out <= '0;
                grs_out  <= '0;
                exp_out  <= '0;
            end else begin
                mant_out <= shifted[FRAC_W-1 -: MANT_W];
                grs_out  <= {shifted[FRAC_W-MANT_W-1], shifted[FRAC_W-MANT_W-2],
                             |shifted[FRAC_W-MANT_W-3:0]};
                exp_out  <= exp_adj;
            end
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_norm_stage.sv
// Directed-vector bench for norm_stage with hand-computed expectations.
module tb_norm_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [74:0] frac_inter;
    logic        frac_inter_h_s, sign_in;
    logic [9:0]  exp_in;
    logic        out_valid, out_ready;
    logic [23:0] mant_out;
    logic [2:0]  grs_out;
    logic [9:0]  exp_out;
    logic        sign_out, zero_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    norm_stage #(.FRAC_W(75), .EXP_W(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .frac_inter     (frac_inter),
        .frac_inter_h_s (frac_inter_h_s),
        .sign_in        (sign_in),
        .exp_in         (exp_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mant_out       (mant_out),
        .grs_out        (grs_out),
        .exp_out        (exp_out),
        .sign_out       (sign_out),
        .zero_out       (zero_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [74:0] f, input logic hs, input logic s, input logic [9:0] e);
        frac_inter     = f;
        frac_inter_h_s = hs;
        sign_in        = s;
        exp_in         = e;
    endtask

    task automatic check_out(input string tag, input logic [23:0] wm, input logic [2:0] wg,
                             input logic [9:0] we, input logic ws, input logic wz);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".mant"},  64'(mant_out),  64'(wm));
        check({tag, ".grs"},   64'(grs_out),   64'(wg));
        check({tag, ".exp"},   64'(exp_out),   64'(we));
        check({tag, ".sign"},  64'(sign_out),  64'(ws));
        check({tag, ".zero"},  64'(zero_out),  64'(wz));
    endtask

    // One operation with out_ready high: result visible after two rising edges.
    task automatic run_one(input string tag, input logic [74:0] f, input logic hs, input logic s,
                           input logic [9:0] e, input logic [23:0] wm, input logic [2:0] wg,
                           input logic [9:0] we, input logic ws, input logic wz);
        @(negedge clk);
        drive(f, hs, s, e);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check_out(tag, wm, wg, we, ws, wz);
    endtask

    logic [74:0] one;
    logic [74:0] f_a, f_b, f_c;

    initial begin
        one = 75'd1;
        f_a = one << 74;
        f_b = one << 60;
        f_c = one << 40;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive('0, 1'b0, 1'b0, '0);

        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.mant",      64'(mant_out),  64'd0);
        check("rst.exp",       64'(exp_out),   64'd0);
        check("rst.zero",      64'(zero_out),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.in_ready",  64'(in_ready),  64'd1);

        run_one("norm0",  f_a, 1'b0, 1'b0, 10'd130, 24'h800000, 3'b000, 10'd130, 1'b0, 1'b0);
        run_one("lzc14",  f_b, 1'b0, 1'b0, 10'd130, 24'h800000, 3'b000, 10'd116, 1'b0, 1'b0);
        run_one("denorm", f_c, 1'b0, 1'b0, 10'd5,   24'h000000, 3'b001, 10'd1,   1'b0, 1'b0);
        run_one("zero",   '0,  1'b0, 1'b1, 10'd77,  24'h000000, 3'b000, 10'd0,   1'b1, 1'b1);
        // Non-positive exponent: no shift, exponent passes through, sign flipped by negative flag.
        run_one("expneg", one << 70, 1'b1, 1'b0, 10'h3FD, 24'h080000, 3'b000, 10'h3FD, 1'b1, 1'b0);
        run_one("grs",    (one << 74) | (one << 50) | (one << 49) | one, 1'b1, 1'b1, 10'd100,
                24'h800000, 3'b111, 10'd100, 1'b0, 1'b0);
        run_one("lzc74",  one, 1'b0, 1'b1, 10'd200, 24'h800000, 3'b000, 10'd126, 1'b1, 1'b0);

        // Back-pressure: three back-to-back offers, output stalled for three cycles.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        drive(f_a, 1'b0, 1'b0, 10'd130);
        #1 check("bp.acc_a", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(f_b, 1'b0, 1'b0, 10'd130);
        #1 check("bp.acc_b", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(f_c, 1'b0, 1'b0, 10'd5);
        #1 check("bp.stall0", 64'(in_ready), 64'd0);
        check_out("bp.hold0", 24'h800000, 3'b000, 10'd130, 1'b0, 1'b0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            check("bp.stall", 64'(in_ready), 64'd0);
            check_out("bp.hold", 24'h800000, 3'b000, 10'd130, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1 check("bp.resume", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("bp.b", 24'h800000, 3'b000, 10'd116, 1'b0, 1'b0);
        @(negedge clk);
        check_out("bp.c", 24'h000000, 3'b001, 10'd1, 1'b0, 1'b0);
        @(negedge clk);
        check("bp.drained", 64'(out_valid), 64'd0);

        // Flush with both stages full and a simultaneous acceptance.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        drive(f_a, 1'b0, 1'b0, 10'd130);
        @(negedge clk);
        drive(f_b, 1'b0, 1'b0, 10'd130);
        @(negedge clk);
        drive(f_c, 1'b0, 1'b0, 10'd5);
        check("fl.full", 64'(out_valid), 64'd1);
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl.out_valid", 64'(out_valid), 64'd0);
        check("fl.in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        check("fl.no_accept", 64'(out_valid), 64'd0);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(f_b, 1'b0, 1'b0, 10'd130);
        @(negedge clk);
        drive(f_c, 1'b0, 1'b0, 10'd5);
        @(negedge clk);
        in_valid = 1'b0;
        check("ar.full", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar.out_valid", 64'(out_valid), 64'd0);
        check("ar.in_ready",  64'(in_ready),  64'd1);
        check("ar.mant",      64'(mant_out),  64'd0);
        check("ar.exp",       64'(exp_out),   64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("ar.rel_ready", 64'(in_ready),  64'd1);
        check("ar.no_pulse0", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("ar.no_pulse1", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
